// File: rtl/boreal_act_pkg.sv
// boreal_act_pkg: shared state encoding and action codes for the actuator slew limiter
package boreal_act_pkg;
  typedef enum logic [2:0] {IDLE, RAMP, HOLD, REVERSE, BRAKE} state_t;
  localparam logic [7:0] ACT_COAST     = 8'd0;
  localparam logic [7:0] ACT_BRAKE     = 8'd1;
  localparam logic [7:0] ACT_DRIVE_MIN = 8'd2;
endpackage

// File: rtl/boreal_tick_gen.sv
// boreal_tick_gen: free-running divider, tick is high for one cycle as the counter wraps
module boreal_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  // counter runs 0..DIV-1 in every state, only rst_n restarts it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/boreal_actuator_slew.sv
// boreal_actuator_slew: rate-limits watchdog actuator commands and presents them on a valid/ready channel
module boreal_actuator_slew
  import boreal_act_pkg::*;
#(
  parameter int          CLK_FREQ = 100_000_000,
  parameter int          TICK_HZ  = 1_000,
  parameter logic [15:0] STEP     = 16'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  hw_act,
  input  logic [15:0] hw_val,
  input  logic        safe_state,
  output logic [7:0]  cmd_act,
  output logic [15:0] cmd_val,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        brake_o,
  output logic        at_target
);
  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  state_t      state;
  logic [7:0]  tgt_act, cur_act;
  logic [15:0] tgt_val, cur_val, step_amt, ramp_nxt, rev_nxt;
  logic [16:0] diff;
  logic        tgt_safe, tick, brake_req, drive, up;
  boreal_tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign brake_req = tgt_safe | (tgt_act == ACT_BRAKE);
  assign drive     = tgt_act >= ACT_DRIVE_MIN;
  assign at_target = state == HOLD;
  // step is clamped to the remaining distance so the ramp lands exactly on target without wrapping
  always_comb begin
    up       = tgt_val >= cur_val;
    diff     = up ? {1'b0, tgt_val} - {1'b0, cur_val} : {1'b0, cur_val} - {1'b0, tgt_val};
    step_amt = diff > {1'b0, STEP} ? STEP : diff[15:0];
    ramp_nxt = up ? cur_val + step_amt : cur_val - step_amt;
    rev_nxt  = cur_val > STEP ? cur_val - STEP : '0;
  end
  // all decisions work from a registered copy of the watchdog outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tgt_act  <= '0;
      tgt_val  <= '0;
      tgt_safe <= 1'b0;
    end else begin
      tgt_act  <= hw_act;
      tgt_val  <= hw_val;
      tgt_safe <= safe_state;
    end
  // slew state machine; brake preempts everything and ignores any coincident tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cur_act <= ACT_COAST;
      cur_val <= '0;
      brake_o <= 1'b0;
    end else if (state == BRAKE) begin
      if (brake_req) cur_val <= tgt_val;
      else begin
        state   <= IDLE;
        cur_act <= ACT_COAST;
        cur_val <= '0;
        brake_o <= 1'b0;
      end
    end else if (brake_req) begin
      state   <= BRAKE;
      cur_act <= ACT_BRAKE;
      cur_val <= tgt_val;
      brake_o <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (drive) begin
            state   <= RAMP;
            cur_act <= tgt_act;
          end
        RAMP:
          if (tgt_act != cur_act) begin
            state <= REVERSE;
            if (tick) cur_val <= rev_nxt;
          end else if (cur_val == tgt_val) state <= HOLD;
          else if (tick) cur_val <= ramp_nxt;
        HOLD:
          if (tgt_act != cur_act) state <= REVERSE;
          else if (tgt_val != cur_val) state <= RAMP;
        REVERSE:
          if (cur_val == '0) begin
            cur_act <= drive ? tgt_act : ACT_COAST;
            state   <= drive ? RAMP : IDLE;
          end else if (tick) cur_val <= rev_nxt;
        default: state <= IDLE;
      endcase
    end
  // cmd_act/cmd_val double as the last accepted pair once valid drops, so new loads coalesce to the latest value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_act   <= '0;
      cmd_val   <= '0;
    end else if (cmd_valid) begin
      if (cmd_ready) cmd_valid <= 1'b0;
    end else if (cur_act != cmd_act || cur_val != cmd_val) begin
      cmd_valid <= 1'b1;
      cmd_act   <= cur_act;
      cmd_val   <= cur_val;
    end
endmodule

// File: doc/boreal_actuator_slew.md
Name: boreal_actuator_slew

Overview:
- Downstream consumer of the watchdog's gated actuator outputs (hw_act/hw_val, safe-state flag).
- Converts step changes in the commanded value into rate-limited ramps at a fixed tick rate.
- Ramps to zero before any drive-direction change; bypasses ramping entirely for brake.
- Presents the result to the actuator serializer over a valid/ready command channel, plus a low-latency level brake line.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- TICK_HZ, 1_000, slew update rate in Hz; tick period TICK_DIV = CLK_FREQ/TICK_HZ cycles (must be ≥2).
- STEP, 64, maximum |change| of the internal value per tick (16-bit unsigned, nonzero).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- hw_act  in  8  action code from watchdog: 0 = coast, 1 = brake, ≥2 = drive (code selects direction/mode).
- hw_val  in  16  target magnitude from watchdog.
- safe_state  in  1  watchdog safe-state flag (level).
- cmd_act  out  8  presented action code.
- cmd_val  out  16  presented magnitude.
- cmd_valid  out  1  command pending.
- cmd_ready  in  1  serializer accepts.
- brake_o  out  1  registered brake level, independent of the handshake.
- at_target  out  1  high in HOLD.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; tick counter 0; cur_act=0; cur_val=0; input registers 0.
- Inputs are registered every cycle into tgt_act/tgt_val/tgt_safe. All decisions below use the registered copies; input-to-state latency is 1 cycle.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick pulses for 1 cycle at wrap. The counter free-runs in every state and never resets except on rst_n.
- brake_req = tgt_safe | (tgt_act==1). brake_req has priority over everything else.
- States:
  - IDLE:
    - cur_act=0, cur_val=0.
    - brake_req → BRAKE.
    - tgt_act≥2 → RAMP (cur_act=tgt_act).
    - tgt_act==0 → stay.
  - RAMP:
    - On tick, cur_val moves toward tgt_val by min(STEP, |tgt_val-cur_val|). Unsigned arithmetic, computed in 17 bits; never wraps or overshoots.
    - cur_val==tgt_val → HOLD.
    - tgt_act ≠ cur_act:
      - tgt_act==0 → REVERSE with goal 0, next act 0.
      - tgt_act≥2 → REVERSE.
  - HOLD:
    - at_target=1.
    - tgt_val ≠ cur_val with the same act → RAMP.
    - Act change → REVERSE.
  - REVERSE:
    - On tick, cur_val steps toward 0 by STEP.
    - When cur_val==0: cur_act=latest tgt_act. Next state is RAMP if tgt_act≥2, else IDLE.
  - BRAKE:
    - cur_act=1, cur_val=tgt_val (no slew, follows input each cycle).
    - Exit when brake_req has been low for 1 full cycle: cur_act=0, cur_val=0, → IDLE. Ramps then restart from 0.
- brake_o is set in the cycle BRAKE is entered (1 cycle after the input) and cleared on exit. It never waits on cmd_ready.
- Command channel:
  - When cmd_valid=0 and (cur_act,cur_val) ≠ last accepted pair, load cmd_act/cmd_val and assert cmd_valid next cycle.
  - While cmd_valid & !cmd_ready, cmd_act/cmd_val are held stable. Intermediate internal values are coalesced; only the latest is sent after the handshake.
  - Handshake completes on cmd_valid & cmd_ready. cmd_valid drops for at least 1 cycle before the next load.
- Simultaneous events:
  - brake_req and tick in the same cycle → BRAKE; the tick is ignored.
  - Act change and tick in RAMP → REVERSE; this tick already applies toward 0.
- Reset mid-handshake: cmd_valid drops asynchronously. The serializer must tolerate this.

Decomposition:
- Package boreal_act_pkg holds:
  - state enum (IDLE, RAMP, HOLD, REVERSE, BRAKE);
  - ACT_COAST=8'd0, ACT_BRAKE=8'd1, ACT_DRIVE_MIN=8'd2.
- Sub-module boreal_tick_gen (parameter DIV, output tick) is natural and reusable.
- The step/saturation math stays inline.

Test Plan:
- Basic ramp: STEP=64, TICK_DIV=4, cmd_ready=1, hw_act=2, hw_val=200 from IDLE → cmd_val sequence 64,128,192,200 on successive ticks, then at_target=1 and no further commands.
- Reversal: in HOLD at act 2/val 200, set hw_act=3, hw_val=100 → values 136,72,8,0 with act 2, then act 3 ramping 64,100. Act never changes while cur_val≠0.
- Brake from watchdog: mid-ramp, pulse safe_state for 5 cycles with hw_act=1, hw_val=1 → brake_o=1 exactly 1 cycle after safe_state rises, cmd_act=1, cmd_val=1. After release, IDLE and restart from 0.
- Backpressure: cmd_ready=0 for 20 cycles during a ramp → cmd_act/cmd_val stable the whole time. After ready, the latest coalesced value is delivered, then a new command follows ≥1 cycle later.
- Boundaries:
  - hw_val=16'hFFFF, STEP=64 → reaches FFFF without overflow; last step 63.
  - Target below STEP (hw_val=10) → a single step to 10.
- Async reset: assert rst_n=0 mid-ramp with cmd_valid=1 → all outputs 0 immediately. After release, IDLE with the tick counter restarted.
